// File: rtl/bin2bcd16.sv
// bin2bcd16 - sequential 16-bit binary to 4-digit packed BCD converter.
// Uses double-dabble, one bit per clock. A conversion takes 16 cycles and
// back-to-back throughput is one conversion per 17 cycles. bcd/ovf are held
// registers that change only on the done edge or on reset.
// Build option: BIN2BCD_SATURATE_EN selects the display shown for values
// above 9999. Defined: 16'h9999. Undefined: 16'hEEEE.
//
// state | meaning
// IDLE  | waiting for start; bcd/ovf hold the last result
// SHIFT | 16 add-3/shift steps in progress, busy=1
`timescale 1ns/1ps

module bin2bcd16 #(
  parameter logic [15:0] RESET_BCD = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] bin,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        ovf,
  output logic [15:0] bcd
);

`ifdef BIN2BCD_SATURATE_EN
  localparam logic [15:0] OVF_PAT = 16'h9999;
`else
  localparam logic [15:0] OVF_PAT = 16'hEEEE;
`endif

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        w_accept;
  logic        w_last;

  logic [15:0] r_shift;
  logic [15:0] r_scratch;
  logic [4:0]  r_cnt;
  logic        r_ovf_pend;
  logic [15:0] r_bcd;
  logic        r_ovf;
  logic        r_done;

  logic [15:0] w_adj;
  logic [15:0] w_scratch_nxt;
  logic        w_ovf_fin;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next state; start is only looked at in IDLE, so it is ignored while busy
  // and on the edge where the last step completes.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_last      = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_accept    = 1'b1;
          w_state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (r_cnt == 5'd15) begin
          w_last      = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Add-3 correction on every nibble >= 5, all in parallel.
  always_comb begin
    w_adj = r_scratch;
    for (int k = 0; k < 4; k++) begin
      if (r_scratch[4*k +: 4] >= 4'd5)
        w_adj[4*k +: 4] = r_scratch[4*k +: 4] + 4'd3;
    end
  end

  // Shift {scratch, shift} left by one. The carry out of the top nibble can
  // only be set for inputs above 9999, so it is folded into the overflow flag
  // rather than being silently dropped.
  assign w_scratch_nxt = {w_adj[14:0], r_shift[15]};
  assign w_ovf_fin     = r_ovf_pend | w_adj[15];

  // Datapath: capture on accept, one step per SHIFT cycle, publish on the last step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift    <= 16'h0000;
      r_scratch  <= 16'h0000;
      r_cnt      <= 5'd0;
      r_ovf_pend <= 1'b0;
      r_bcd      <= RESET_BCD;
      r_ovf      <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= w_last;
      if (w_accept) begin
        r_shift    <= bin;
        r_scratch  <= 16'h0000;
        r_cnt      <= 5'd0;
        r_ovf_pend <= (bin > 16'd9999);
      end else if (r_state == SHIFT) begin
        r_scratch <= w_scratch_nxt;
        r_shift   <= {r_shift[14:0], 1'b0};
        r_cnt     <= r_cnt + 5'd1;
        if (w_last) begin
          r_bcd <= w_ovf_fin ? OVF_PAT : w_scratch_nxt;
          r_ovf <= w_ovf_fin;
        end
      end
    end
  end

  assign busy = (r_state == SHIFT);
  assign done = r_done;
  assign ovf  = r_ovf;
  assign bcd  = r_bcd;

endmodule

// File: tb/tb_bin2bcd16.sv
// tb_bin2bcd16 - self-checking bench for bin2bcd16 (RESET_BCD default).
`timescale 1ns/1ps

module tb_bin2bcd16;

`ifdef BIN2BCD_SATURATE_EN
  localparam logic [15:0] OVF_PAT = 16'h9999;
`else
  localparam logic [15:0] OVF_PAT = 16'hEEEE;
`endif

  logic        clk   = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic [15:0] bin   = 16'h0000;
  logic        busy;
  logic        done;
  logic        ovf;
  logic [15:0] bcd;

  int n_pass  = 0;
  int n_total = 0;

  bin2bcd16 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bin   (bin),
    .start (start),
    .busy  (busy),
    .done  (done),
    .ovf   (ovf),
    .bcd   (bcd)
  );

  always #5 clk = ~clk;

  // Reference: decimal digits by plain arithmetic.
  function automatic logic [15:0] ref_bcd(input int v);
    int d;
    if (v > 9999) return OVF_PAT;
    d = ((v / 1000) % 10) * 4096 + ((v / 100) % 10) * 256 + ((v / 10) % 10) * 16 + (v % 10);
    return 16'(d);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Called #1 after the accept edge: waits (bounded) for done and checks it.
  task automatic wait_done(input string tag, input int v);
    int lat;
    bit seen;
    bit busy_ok;
    lat = 0; seen = 1'b0; busy_ok = 1'b1;
    while (!seen && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (done) seen = 1'b1;
      else if (!busy) busy_ok = 1'b0;
    end
    chk({tag, " latency"}, 32'(lat), 32'd16);
    chk({tag, " busy held"}, 32'(busy_ok), 32'd1);
    chk({tag, " bcd"}, 32'(bcd), 32'(ref_bcd(v)));
    chk({tag, " ovf"}, 32'(ovf), 32'(v > 9999));
    chk({tag, " busy at done"}, 32'(busy), 32'd0);
  endtask

  task automatic run_one(input int v, input string tag);
    @(negedge clk);
    bin = 16'(v); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; bin = 16'($urandom);
    chk({tag, " busy at accept"}, 32'(busy), 32'd1);
    wait_done(tag, v);
    @(posedge clk); #1;
    chk({tag, " done pulse"}, 32'(done), 32'd0);
  endtask

  initial begin
    bit stable;
    bit seen;
    int v;

    #2 rst_n = 1'b0;
    #1;
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    chk("reset ovf",  32'(ovf),  32'd0);
    chk("reset bcd",  32'(bcd),  32'h0000);
    @(negedge clk) rst_n = 1'b1;

    run_one(1234, "v1234");
    stable = 1'b1;
    repeat (20) begin
      @(posedge clk); #1;
      if (bcd !== 16'h1234 || ovf !== 1'b0 || busy !== 1'b0) stable = 1'b0;
    end
    chk("hold 20 idle", 32'(stable), 32'd1);

    run_one(9999,  "v9999");
    run_one(0,     "v0");
    run_one(10,    "v10");
    run_one(10000, "v10000");
    run_one(65535, "v65535");
    run_one(42,    "v42 after ovf");

    // start pulses at E5 and E16 with a different bin are ignored
    @(negedge clk);
    bin = 16'd1234; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 1; k <= 17; k++) begin
      start = (k == 5 || k == 16);
      if (start) bin = 16'd777;
      @(posedge clk); #1;
      if (k == 5)  chk("ign busy E5", 32'(busy), 32'd1);
      if (k == 16) begin
        chk("ign done E16", 32'(done), 32'd1);
        chk("ign bcd",      32'(bcd),  32'h1234);
        chk("ign busy E16", 32'(busy), 32'd0);
      end
      if (k == 17) chk("ign no restart E17", 32'(busy), 32'd0);
    end
    start = 1'b0;

    // reset mid-conversion at E8
    @(negedge clk);
    bin = 16'd5555; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (8) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst busy", 32'(busy), 32'd0);
    chk("midrst bcd",  32'(bcd),  32'h0000);
    chk("midrst done", 32'(done), 32'd0);
    seen = 1'b0;
    repeat (12) begin
      @(posedge clk); #1;
      if (done || busy) seen = 1'b1;
    end
    chk("midrst no done", 32'(seen), 32'd0);
    bin = 16'd0; start = 1'b1;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("first edge accept", 32'(busy), 32'd1);
    wait_done("post-reset v0", 0);

    // start held high: one conversion every 17 cycles, bin re-sampled
    @(negedge clk);
    start = 1'b1;
    for (v = 0; v <= 50; v++) begin
      bin = 16'(v);
      @(posedge clk); #1;
      chk("held accept busy", 32'(busy), 32'd1);
      if (v > 0) chk("held done low", 32'(done), 32'd0);
      bin = 16'($urandom);
      repeat (15) @(posedge clk);
      @(posedge clk); #1;
      chk("held done", 32'(done), 32'd1);
      chk("held bcd", 32'(bcd), 32'(ref_bcd(v)));
    end
    start = 1'b0;
    @(posedge clk); #1;

    // randomized values, half restricted to the displayable range
    for (int i = 0; i < 40; i++) begin
      if (i % 2 == 0) run_one(int'($urandom_range(0, 9999)), "rand in-range");
      else            run_one(int'($urandom_range(0, 65535)), "rand full");
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
